// File: rtl/song_pkg.sv
// Shared constants for the song sequencer: pitch indices, ROM entry layout, FSM states
// and the entry builders used to fill the melody ROM.
package song_pkg;

  localparam int unsigned PITCH_W   = 3;
  localparam int unsigned DUR_W     = 2;
  localparam int unsigned ENTRY_W   = 7;
  localparam int unsigned END_BIT   = 6;
  localparam int unsigned REST_BIT  = 5;
  localparam int unsigned DUR_LSB   = 3;
  localparam int unsigned PITCH_LSB = 0;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned STEP_W    = 6;

  localparam logic [PITCH_W-1:0] PITCH_DO  = 3'd0;
  localparam logic [PITCH_W-1:0] PITCH_RE  = 3'd1;
  localparam logic [PITCH_W-1:0] PITCH_MI  = 3'd2;
  localparam logic [PITCH_W-1:0] PITCH_FA  = 3'd3;
  localparam logic [PITCH_W-1:0] PITCH_SO  = 3'd4;
  localparam logic [PITCH_W-1:0] PITCH_LA  = 3'd5;
  localparam logic [PITCH_W-1:0] PITCH_TI  = 3'd6;
  localparam logic [PITCH_W-1:0] PITCH_DO1 = 3'd7;

  localparam logic [ADDR_W-1:0] SONG_A_BASE = 7'd0;
  localparam logic [ADDR_W-1:0] SONG_B_BASE = 7'd64;

  localparam logic [ENTRY_W-1:0] END_ENTRY = 7'b100_0000;

  typedef enum logic [2:0] {StIdle, StFetch, StNote, StGap, StDone} state_e;

  function automatic logic [ENTRY_W-1:0] ev(input logic [PITCH_W-1:0] pitch,
                                            input int unsigned beats);
    logic [DUR_W-1:0] dur_m1;
    dur_m1 = DUR_W'(beats - 1);
    return {1'b0, 1'b0, dur_m1, pitch};
  endfunction

  function automatic logic [ENTRY_W-1:0] rest_ev(input int unsigned beats);
    logic [DUR_W-1:0] dur_m1;
    dur_m1 = DUR_W'(beats - 1);
    return {1'b0, 1'b1, dur_m1, 3'd0};
  endfunction

endpackage

// File: rtl/song_rom.sv
// 128x7 melody ROM with a registered output. Song A (Twinkle) at 0, song B (Jingle Bells)
// at 64; unprogrammed locations read as END so a stray address always terminates play.
module song_rom
  import song_pkg::*;
(
  input  logic               i_clk,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [ENTRY_W-1:0] o_data
);

  logic [ENTRY_W-1:0] w_data;
  logic [ENTRY_W-1:0] r_data;

  always_comb begin
    w_data = END_ENTRY;
    case (i_addr)
      7'd0:  w_data = ev(PITCH_DO, 1);
      7'd1:  w_data = ev(PITCH_DO, 1);
      7'd2:  w_data = ev(PITCH_SO, 1);
      7'd3:  w_data = ev(PITCH_SO, 1);
      7'd4:  w_data = ev(PITCH_LA, 1);
      7'd5:  w_data = ev(PITCH_LA, 1);
      7'd6:  w_data = ev(PITCH_SO, 2);
      7'd7:  w_data = rest_ev(1);
      7'd8:  w_data = ev(PITCH_FA, 1);
      7'd9:  w_data = ev(PITCH_FA, 1);
      7'd10: w_data = ev(PITCH_MI, 1);
      7'd11: w_data = ev(PITCH_MI, 1);
      7'd12: w_data = ev(PITCH_RE, 1);
      7'd13: w_data = ev(PITCH_RE, 1);
      7'd14: w_data = ev(PITCH_DO, 2);
      7'd15: w_data = END_ENTRY;
      7'd64: w_data = ev(PITCH_MI, 1);
      7'd65: w_data = ev(PITCH_MI, 1);
      7'd66: w_data = ev(PITCH_MI, 2);
      7'd67: w_data = ev(PITCH_MI, 1);
      7'd68: w_data = ev(PITCH_MI, 1);
      7'd69: w_data = ev(PITCH_MI, 2);
      7'd70: w_data = ev(PITCH_MI, 1);
      7'd71: w_data = ev(PITCH_SO, 1);
      7'd72: w_data = ev(PITCH_DO, 1);
      7'd73: w_data = ev(PITCH_RE, 1);
      7'd74: w_data = ev(PITCH_MI, 4);
      7'd75: w_data = END_ENTRY;
      default: w_data = END_ENTRY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    r_data <= w_data;
  end

  assign o_data = r_data;

endmodule

// File: rtl/song_sequencer.sv
// Counter-driven melody player: fetches ROM entries, holds each note for its beat count
// minus an articulation gap, and emits a one-hot note code for the tone generator.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 6_750_000,
  parameter int unsigned GAP_CYCLES  = 675_000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic        CLOCK_27,
  input  logic        Reset,
  input  logic [1:0]  song_sel,
  input  logic        loop,
  output logic [7:0]  note,
  output logic        playing,
  output logic [5:0]  step,
  output logic        song_done
);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_song;
  logic [STEP_W-1:0]   r_step;
  logic                r_armed;
  logic [7:0]          r_note;
  logic                r_playing;
  logic                r_done;

  logic                w_sel_b;
  logic [STEP_W-1:0]   w_step_inc;
  logic [STEP_W-1:0]   w_off;
  logic [ADDR_W-1:0]   w_base;
  logic [ADDR_W-1:0]   w_addr;
  logic [ENTRY_W-1:0]  w_entry;
  logic                w_is_end;
  logic                w_rest;
  logic [DUR_W-1:0]    w_dur_m1;
  logic [PITCH_W-1:0]  w_pitch;
  logic [31:0]         w_dur_cycles;
  logic [CNT_W-1:0]    w_note_load;
  logic [CNT_W-1:0]    w_gap_load;
  logic [7:0]          w_onehot;
  logic                w_cnt_zero;

  assign w_sel_b    = (song_sel == 2'b10);
  assign w_step_inc = (r_step == 6'd63) ? r_step : r_step + 6'd1;

  // The ROM is registered, so the address must already point at the next entry during the
  // cycle before FETCH: the selected song's base in IDLE, the following entry during GAP.
  always_comb begin
    w_base = r_song ? SONG_B_BASE : SONG_A_BASE;
    w_off  = r_step;
    case (r_state)
      StIdle: begin
        w_base = w_sel_b ? SONG_B_BASE : SONG_A_BASE;
        w_off  = '0;
      end
      StGap:   w_off = w_step_inc;
      default: w_off = r_step;
    endcase
    w_addr = w_base + {1'b0, w_off};
  end

  song_rom u_rom (
    .i_clk  (CLOCK_27),
    .i_addr (w_addr),
    .o_data (w_entry)
  );

  assign w_is_end     = w_entry[END_BIT] | (r_step == 6'd63);
  assign w_rest       = w_entry[REST_BIT];
  assign w_dur_m1     = w_entry[DUR_LSB +: DUR_W];
  assign w_pitch      = w_entry[PITCH_LSB +: PITCH_W];
  assign w_dur_cycles = (32'(w_dur_m1) + 32'd1) * BEAT_CYCLES;
  assign w_note_load  = CNT_W'(w_dur_cycles - GAP_CYCLES - 32'd1);
  assign w_gap_load   = CNT_W'(GAP_CYCLES - 32'd1);
  assign w_onehot     = 8'b1 << w_pitch;
  assign w_cnt_zero   = (r_cnt == '0);

  always_ff @(posedge CLOCK_27 or negedge Reset) begin
    if (!Reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_song    <= 1'b0;
      r_step    <= '0;
      r_armed   <= 1'b1;
      r_note    <= '0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (song_sel == 2'b00) begin
        r_state   <= StIdle;
        r_note    <= '0;
        r_playing <= 1'b0;
        r_armed   <= 1'b1;
      end else begin
        if (loop) r_armed <= 1'b1;
        case (r_state)
          StIdle: begin
            r_note <= '0;
            if (r_armed) begin
              r_song    <= w_sel_b;
              r_step    <= '0;
              r_playing <= 1'b1;
              r_state   <= StFetch;
            end
          end
          StFetch: begin
            if (w_is_end) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_cnt   <= w_note_load;
              r_note  <= w_rest ? 8'h00 : w_onehot;
              r_state <= StNote;
            end
          end
          StNote: begin
            if (w_cnt_zero) begin
              r_note  <= '0;
              r_cnt   <= w_gap_load;
              r_state <= StGap;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          StGap: begin
            if (w_cnt_zero) begin
              r_step  <= w_step_inc;
              r_state <= StFetch;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          StDone: begin
            r_note    <= '0;
            r_playing <= 1'b0;
            if (!loop) r_armed <= 1'b0;
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign note      = r_note;
  assign playing   = r_playing;
  assign step      = r_step;
  assign song_done = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer with short beats: start-up vector table, then scoreboarded
// full-song traces, abort, loop, song-change and asynchronous reset sequences.
module tb_song_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] song_sel;
  logic       loop;
  logic [7:0] note;
  logic       playing;
  logic [5:0] step;
  logic       song_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] note;
    logic       playing;
    logic       done;
    logic [5:0] step;
    logic       chk_step;
  } exp_t;

  typedef struct {
    logic [1:0] sel;
    logic       lp;
    logic [7:0] note;
    logic       playing;
    logic [5:0] step;
    logic       done;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  // Melodies as written in the song book: pitch index (8 = rest) and beats per event.
  int song_a_p[15] = '{0, 0, 4, 4, 5, 5, 4, 8, 3, 3, 2, 2, 1, 1, 0};
  int song_a_d[15] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 2};
  int song_b_p[11] = '{2, 2, 2, 2, 2, 2, 2, 4, 0, 1, 2};
  int song_b_d[11] = '{1, 1, 2, 1, 1, 2, 1, 1, 1, 1, 4};

  song_sequencer #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .CNT_W       (8)
  ) dut (
    .CLOCK_27  (clk),
    .Reset     (rst_n),
    .song_sel  (song_sel),
    .loop      (loop),
    .note      (note),
    .playing   (playing),
    .step      (step),
    .song_done (song_done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) sb.push_back('{8'h00, 1'b0, 1'b0, 6'd0, 1'b0});
  endtask

  task automatic push_song(input bit b);
    int np;
    int p;
    int d;
    np = b ? 11 : 15;
    for (int i = 0; i < np; i++) begin
      p = b ? song_b_p[i] : song_a_p[i];
      d = b ? song_b_d[i] : song_a_d[i];
      sb.push_back('{8'h00, 1'b1, 1'b0, 6'(i), 1'b1});
      for (int k = 0; k < d * BEAT - GAP; k++)
        sb.push_back('{(p == 8) ? 8'h00 : 8'(1 << p), 1'b1, 1'b0, 6'(i), 1'b1});
      for (int k = 0; k < GAP; k++) sb.push_back('{8'h00, 1'b1, 1'b0, 6'(i), 1'b1});
    end
    sb.push_back('{8'h00, 1'b1, 1'b0, 6'(np), 1'b1});
    sb.push_back('{8'h00, 1'b1, 1'b1, 6'(np), 1'b1});
  endtask

  task automatic run_sb(input int chg_at, input logic [1:0] chg_sel);
    exp_t e;
    int n;
    n = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check("sb_note", n, 32'(note), 32'(e.note));
      check("sb_playing", n, 32'(playing), 32'(e.playing));
      check("sb_done", n, 32'(song_done), 32'(e.done));
      if (e.chk_step) check("sb_step", n, 32'(step), 32'(e.step));
      if (n == chg_at) song_sel = chg_sel;
      n++;
    end
  endtask

  initial begin
    vecs[0] = '{2'b01, 1'b0, 8'h00, 1'b1, 6'd0, 1'b0};
    for (int i = 1; i <= 8; i++) vecs[i] = '{2'b01, 1'b0, 8'h01, 1'b1, 6'd0, 1'b0};
    vecs[9]  = '{2'b01, 1'b0, 8'h00, 1'b1, 6'd0, 1'b0};
    vecs[10] = '{2'b01, 1'b0, 8'h00, 1'b1, 6'd0, 1'b0};
    vecs[11] = '{2'b01, 1'b0, 8'h00, 1'b1, 6'd1, 1'b0};
    vecs[12] = '{2'b01, 1'b0, 8'h01, 1'b1, 6'd1, 1'b0};

    rst_n    = 1'b0;
    song_sel = 2'b00;
    loop     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_note", 0, 32'(note), 32'h0);
    check("rst_playing", 0, 32'(playing), 32'h0);
    check("rst_step", 0, 32'(step), 32'h0);
    check("rst_done", 0, 32'(song_done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_playing", 0, 32'(playing), 32'h0);

    // Start-up timing of song A.
    foreach (vecs[i]) begin
      song_sel = vecs[i].sel;
      loop     = vecs[i].lp;
      @(negedge clk);
      check("vec_note", i, 32'(note), 32'(vecs[i].note));
      check("vec_playing", i, 32'(playing), 32'(vecs[i].playing));
      check("vec_step", i, 32'(step), 32'(vecs[i].step));
      check("vec_done", i, 32'(song_done), 32'(vecs[i].done));
    end

    // Abort mid-note: silence and IDLE next edge, never a done pulse.
    song_sel = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_note", i, 32'(note), 32'h0);
      check("abort_playing", i, 32'(playing), 32'h0);
      check("abort_done", i, 32'(song_done), 32'h0);
    end

    // Song A to completion, no restart while song_sel stays at 01.
    song_sel = 2'b01;
    push_song(1'b0);
    push_idle(20);
    run_sb(-1, 2'b00);

    // Looping restart.
    song_sel = 2'b00;
    @(negedge clk);
    song_sel = 2'b01;
    loop     = 1'b1;
    push_song(1'b0);
    push_idle(1);
    sb.push_back('{8'h00, 1'b1, 1'b0, 6'd0, 1'b1});
    for (int i = 0; i < 8; i++) sb.push_back('{8'h01, 1'b1, 1'b0, 6'd0, 1'b1});
    run_sb(-1, 2'b00);
    song_sel = 2'b00;
    loop     = 1'b0;
    @(negedge clk);

    // 11 plays song A; switching to song B mid-song is ignored.
    song_sel = 2'b11;
    push_song(1'b0);
    push_idle(10);
    run_sb(40, 2'b10);

    // Song B.
    song_sel = 2'b00;
    @(negedge clk);
    song_sel = 2'b10;
    push_song(1'b1);
    push_idle(3);
    run_sb(-1, 2'b00);

    // Asynchronous reset during the second event's gap.
    song_sel = 2'b00;
    @(negedge clk);
    song_sel = 2'b01;
    repeat (21) @(negedge clk);
    check("pre_rst_step", 0, 32'(step), 32'd1);
    check("pre_rst_playing", 0, 32'(playing), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_note", 0, 32'(note), 32'h0);
    check("async_rst_step", 0, 32'(step), 32'h0);
    check("async_rst_playing", 0, 32'(playing), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset while a note sounds.
    repeat (5) @(negedge clk);
    check("pre_rst_note", 1, 32'(note), 32'h01);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_note", 1, 32'(note), 32'h0);
    check("async_rst_playing", 1, 32'(playing), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    song_sel = 2'b00;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
